// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one operation at a time to a combinational sel-coded ALU.
// It decodes aluop/funct into the ALU sel code and holds the operands stable for a
// per-operation settle window. The captured result goes back over a valid/ready channel.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_aluop, req_funct           operation encoding
//   req_a, req_b                   operands
//   alu_a, alu_b, alu_sel          registered ALU drive
//   alu_res, alu_zf                ALU result / zero flag (combinational from alu_*)
//   rsp_valid/rsp_ready            response handshake
//   rsp_res, rsp_zf, rsp_err       captured result, zero flag, error code
module alu_issue_ctrl #(
   parameter int unsigned W          = 32,
   parameter int unsigned FAST_LAT   = 1,
   parameter int unsigned MULDIV_LAT = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_aluop,
   input  logic [5:0]   req_funct,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [3:0]   alu_sel,
   input  logic [W-1:0] alu_res,
   input  logic         alu_zf,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_res,
   output logic         rsp_zf,
   output logic [1:0]   rsp_err
);

   localparam int unsigned CNT_W = 16;

   localparam logic [3:0] SEL_AND = 4'b0000;
   localparam logic [3:0] SEL_OR  = 4'b0001;
   localparam logic [3:0] SEL_ADD = 4'b0010;
   localparam logic [3:0] SEL_RST = 4'b0011;
   localparam logic [3:0] SEL_NOR = 4'b0100;
   localparam logic [3:0] SEL_MUL = 4'b0101;
   localparam logic [3:0] SEL_SUB = 4'b0110;
   localparam logic [3:0] SEL_DIV = 4'b1000;
   localparam logic [3:0] SEL_SLT = 4'b1001;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_ILL  = 2'b01;
   localparam logic [1:0] ERR_DIV0 = 2'b10;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [W-1:0]       alu_a_d, alu_b_d, rsp_res_d;
   logic [3:0]         alu_sel_d;
   logic               rsp_zf_d;
   logic [1:0]         rsp_err_d;

   logic [3:0]         dec_sel_c;
   logic               dec_ill_c;

   // Request decode: aluop selects ADD/SUB directly, R-type goes through funct.
   always_comb begin
      dec_sel_c = SEL_RST;
      dec_ill_c = 1'b0;
      unique case (req_aluop)
         2'b00: dec_sel_c = SEL_ADD;
         2'b01: dec_sel_c = SEL_SUB;
         2'b10: begin
            unique case (req_funct)
               6'h20:   dec_sel_c = SEL_ADD;
               6'h22:   dec_sel_c = SEL_SUB;
               6'h24:   dec_sel_c = SEL_AND;
               6'h25:   dec_sel_c = SEL_OR;
               6'h27:   dec_sel_c = SEL_NOR;
               6'h2A:   dec_sel_c = SEL_SLT;
               6'h18:   dec_sel_c = SEL_MUL;
               6'h1A:   dec_sel_c = SEL_DIV;
               default: dec_ill_c = 1'b1;
            endcase
         end
         default: dec_ill_c = 1'b1;
      endcase
   end

   // Next-state and next-output logic; every register holds by default.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      alu_a_d   = alu_a;
      alu_b_d   = alu_b;
      alu_sel_d = alu_sel;
      rsp_res_d = rsp_res;
      rsp_zf_d  = rsp_zf;
      rsp_err_d = rsp_err;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (dec_ill_c) begin
                  state_d   = RESP;
                  rsp_res_d = '0;
                  rsp_zf_d  = 1'b0;
                  rsp_err_d = ERR_ILL;
               end else if (dec_sel_c == SEL_DIV && req_b == '0) begin
                  // Divide by zero is answered without touching the ALU.
                  state_d   = RESP;
                  rsp_res_d = '1;
                  rsp_zf_d  = 1'b0;
                  rsp_err_d = ERR_DIV0;
               end else begin
                  state_d   = EXEC;
                  alu_a_d   = req_a;
                  alu_b_d   = req_b;
                  alu_sel_d = dec_sel_c;
                  cnt_d     = (dec_sel_c == SEL_MUL || dec_sel_c == SEL_DIV) ?
                              CNT_W'(MULDIV_LAT) : CNT_W'(FAST_LAT);
               end
            end
         end
         EXEC: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d   = RESP;
               rsp_res_d = alu_res;
               rsp_zf_d  = alu_zf;
               rsp_err_d = ERR_OK;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; handshake flags follow the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= SEL_RST;
         rsp_res   <= '0;
         rsp_zf    <= 1'b0;
         rsp_err   <= ERR_OK;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         alu_a     <= alu_a_d;
         alu_b     <= alu_b_d;
         alu_sel   <= alu_sel_d;
         rsp_res   <= rsp_res_d;
         rsp_zf    <= rsp_zf_d;
         rsp_err   <= rsp_err_d;
         req_ready <= (state_d == IDLE);
         rsp_valid <= (state_d == RESP);
      end
   end

endmodule
